puzzle_arbiter: RTL and testbench



---
 rtl/puzzle_pkg.sv | 13 +
 rtl/puzzle_starve_ctr.sv | 31 +++
 rtl/puzzle_arbiter.sv | 117 +++++++++++
 tb/tb_puzzle_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared constants and types for the puzzle RAM arbiter.
// The CPU FSM only needs to remember whether a read return is due this cycle.
package puzzle_pkg;

  localparam int PUZ_ADDR_W = 13;
  localparam int PUZ_DATA_W = 32;

  typedef enum logic {
    CPU_IDLE,
    CPU_RD_RET
  } cpu_state_t;

endpackage

// File: rtl/puzzle_starve_ctr.sv
// Saturating up-counter with synchronous clear.
// Counts consecutive arbitration cycles the CPU has lost.
module puzzle_starve_ctr #(
  parameter  int MAX_COUNT = 4,
  localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic             at_max;

  assign at_max = (count_reg == CNT_W'(MAX_COUNT));
  assign count  = count_reg;

  // Clear takes precedence so a grant always restarts the wait window.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !at_max) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/puzzle_arbiter.sv
// Shares the single-port puzzle RAM between the CPU Avalon slave and the
// display fetch engine: display first, CPU forced through after MAX_CPU_WAIT losses.
module puzzle_arbiter
  import puzzle_pkg::*;
#(
  parameter int ADDR_W       = PUZ_ADDR_W,
  parameter int DATA_W       = PUZ_DATA_W,
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  output logic                AVL_WAITREQUEST,
  input  logic                DISP_REQ,
  input  logic [ADDR_W-1:0]   DISP_ADDR,
  output logic                DISP_GNT,
  output logic                DISP_VALID,
  output logic [DATA_W-1:0]   DISP_DATA,
  output logic [ADDR_W-1:0]   RAM_ADDR,
  output logic [DATA_W/8-1:0] RAM_BYTE_EN,
  output logic [DATA_W-1:0]   RAM_DATA,
  output logic                RAM_RDEN,
  output logic                RAM_WREN,
  input  logic [DATA_W-1:0]   RAM_Q
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STARVE_W = $clog2(MAX_CPU_WAIT + 1);

  cpu_state_t          state_reg;
  cpu_state_t          state_next;
  logic                disp_valid_reg;
  logic [STARVE_W-1:0] starve;

  logic cpu_active;
  logic cpu_req;
  logic cpu_gnt;
  logic cpu_wr_gnt;
  logic cpu_rd_gnt;
  logic disp_gnt;
  logic starve_full;
  logic in_rd_ret;

  assign in_rd_ret   = (state_reg == CPU_RD_RET);
  assign cpu_active  = AVL_CS & (AVL_READ | AVL_WRITE);
  // While the read data is returning the CPU still holds its request; mask it.
  assign cpu_req     = cpu_active & ~in_rd_ret;
  assign starve_full = (starve == STARVE_W'(MAX_CPU_WAIT));
  assign cpu_gnt     = cpu_req & (~DISP_REQ | starve_full);
  // A simultaneous read+write is served as a write.
  assign cpu_wr_gnt  = cpu_gnt & AVL_WRITE;
  assign cpu_rd_gnt  = cpu_gnt & ~AVL_WRITE;
  assign disp_gnt    = DISP_REQ & ~cpu_gnt;

  puzzle_starve_ctr #(
    .MAX_COUNT (MAX_CPU_WAIT)
  ) u_starve_ctr (
    .clk   (CLK),
    .srst  (RESET),
    .inc   (cpu_req & ~cpu_gnt),
    .clr   (cpu_gnt),
    .count (starve)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= CPU_IDLE;
      disp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      disp_valid_reg <= disp_gnt;
    end
  end

  always_comb begin
    state_next      = state_reg;
    AVL_WAITREQUEST = cpu_active;
    AVL_READDATA    = '0;
    case (state_reg)
      CPU_IDLE: begin
        if (cpu_rd_gnt) begin
          state_next = CPU_RD_RET;
        end
        if (cpu_wr_gnt) begin
          AVL_WAITREQUEST = 1'b0;
        end
      end
      CPU_RD_RET: begin
        state_next      = CPU_IDLE;
        AVL_WAITREQUEST = 1'b0;
        AVL_READDATA    = RAM_Q;
      end
      default: state_next = CPU_IDLE;
    endcase
  end

  assign DISP_GNT   = disp_gnt;
  assign DISP_VALID = disp_valid_reg;
  assign DISP_DATA  = disp_valid_reg ? RAM_Q : '0;

  assign RAM_ADDR = disp_gnt ? DISP_ADDR : AVL_ADDR;
  assign RAM_DATA = AVL_WRITEDATA;
  assign RAM_RDEN = cpu_rd_gnt | disp_gnt;
  assign RAM_WREN = cpu_wr_gnt;

  // Byte lanes are only narrowed for CPU writes; reads always fetch full words.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
    assign RAM_BYTE_EN[gi] = cpu_wr_gnt ? AVL_BYTE_EN[gi] : 1'b1;
  end

endmodule

// File: tb/tb_puzzle_arbiter.sv
// Self-checking bench for puzzle_arbiter: table vectors, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_puzzle_arbiter;

  localparam int AW   = 13;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          RESET;
  logic [AW-1:0] AVL_ADDR;
  logic [BW-1:0] AVL_BYTE_EN;
  logic          AVL_CS, AVL_READ, AVL_WRITE;
  logic [DW-1:0] AVL_WRITEDATA, AVL_READDATA;
  logic          AVL_WAITREQUEST;
  logic          DISP_REQ;
  logic [AW-1:0] DISP_ADDR;
  logic          DISP_GNT, DISP_VALID;
  logic [DW-1:0] DISP_DATA;
  logic [AW-1:0] RAM_ADDR;
  logic [BW-1:0] RAM_BYTE_EN;
  logic [DW-1:0] RAM_DATA;
  logic          RAM_RDEN, RAM_WREN;
  logic [DW-1:0] RAM_Q;

  always #5 clk = ~clk;

  puzzle_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_WAIT(MAXW)) dut (
    .CLK(clk), .RESET(RESET),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_CS(AVL_CS),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_BYTE_EN(RAM_BYTE_EN), .RAM_DATA(RAM_DATA),
    .RAM_RDEN(RAM_RDEN), .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
  );

  // RAM: byte-enabled write, one-cycle registered read
  logic [DW-1:0] mem [0:8191];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else begin
      if (RAM_WREN)
        for (int b = 0; b < BW; b++)
          if (RAM_BYTE_EN[b]) mem[RAM_ADDR][b*8 +: 8] <= RAM_DATA[b*8 +: 8];
      if (RAM_RDEN) RAM_Q <= mem[RAM_ADDR];
    end
  end

  // Reference model: shadow memory plus "who owes data to whom" bookkeeping
  logic [DW-1:0] gold [0:8191];
  int            lost;
  bit            m_cpu_ret, m_disp_ret;
  logic [DW-1:0] m_cpu_data, m_disp_data;
  bit            cpu_wants, cpu_wins, disp_wins, e_wait, e_rden, e_wren;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic sample();
    #1;
    cpu_wants = AVL_CS && (AVL_READ || AVL_WRITE) && !m_cpu_ret;
    cpu_wins  = cpu_wants && (!DISP_REQ || lost >= MAXW);
    disp_wins = DISP_REQ && !cpu_wins;
    e_wait    = AVL_CS && (AVL_READ || AVL_WRITE) && !(cpu_wins && AVL_WRITE) && !m_cpu_ret;
    e_wren    = cpu_wins && AVL_WRITE;
    e_rden    = (cpu_wins && !AVL_WRITE) || disp_wins;
    chk("disp_gnt", 32'(DISP_GNT), 32'(disp_wins));
    chk("waitrequest", 32'(AVL_WAITREQUEST), 32'(e_wait));
    chk("ram_rden", 32'(RAM_RDEN), 32'(e_rden));
    chk("ram_wren", 32'(RAM_WREN), 32'(e_wren));
    chk("ram_addr", 32'(RAM_ADDR), 32'(disp_wins ? DISP_ADDR : AVL_ADDR));
    chk("ram_byte_en", 32'(RAM_BYTE_EN), 32'(e_wren ? AVL_BYTE_EN : 4'hF));
    if (e_wren) chk("ram_data", RAM_DATA, AVL_WRITEDATA);
    chk("avl_readdata", AVL_READDATA, m_cpu_ret ? m_cpu_data : 32'h0);
    chk("disp_valid", 32'(DISP_VALID), 32'(m_disp_ret));
    chk("disp_data", DISP_DATA, m_disp_ret ? m_disp_data : 32'h0);
  endtask

  task automatic advance();
    bit            n_cpu_ret, n_disp_ret;
    logic [DW-1:0] n_cpu_data, n_disp_data;
    n_cpu_ret   = cpu_wins && !AVL_WRITE;
    n_cpu_data  = gold[AVL_ADDR];
    n_disp_ret  = disp_wins;
    n_disp_data = gold[DISP_ADDR];
    if (e_wren)
      for (int b = 0; b < BW; b++)
        if (AVL_BYTE_EN[b]) gold[AVL_ADDR][b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
    if (cpu_wins) lost = 0;
    else if (cpu_wants) lost = (lost < MAXW) ? lost + 1 : MAXW;
    m_cpu_ret = n_cpu_ret;   m_cpu_data  = n_cpu_data;
    m_disp_ret = n_disp_ret; m_disp_data = n_disp_data;
    if (RESET) begin
      lost = 0; m_cpu_ret = 0; m_disp_ret = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0; AVL_BYTE_EN = '0;
    AVL_WRITEDATA = '0; DISP_REQ = 0; DISP_ADDR = '0;
  endtask

  // Holds a CPU read against continuous display traffic until it is served
  task automatic starve_read(input logic [AW-1:0] a, output int req_cycles, output int stalls);
    bit granted;
    req_cycles = -1;
    stalls = 0;
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = a;
    for (int k = 1; k <= 20; k++) begin
      sample();
      granted = RAM_RDEN && !DISP_GNT && (RAM_ADDR == a);
      if (!DISP_GNT) stalls++;
      advance();
      if (!granted) DISP_ADDR = DISP_ADDR + 1'b1;
      if (granted) begin
        req_cycles = k;
        break;
      end
    end
    sample();
    chk("starve_ret_wait", 32'(AVL_WAITREQUEST), 32'h0);
    chk("starve_ret_data", AVL_READDATA, 32'hC0DE0000 | 32'(a));
    chk("starve_ret_disp_gnt", 32'(DISP_GNT), 32'h1);
    advance();
    DISP_ADDR = DISP_ADDR + 1'b1;
    AVL_CS = 0; AVL_READ = 0;
  endtask

  typedef struct {
    logic          cs, rd, wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          e_gnt, e_wait;
    logic [DW-1:0] e_rdata;
    logic          e_dvalid;
    logic [DW-1:0] e_ddata;
  } vec_t;

  function automatic vec_t mk(logic cs, logic rd, logic wr, logic [AW-1:0] addr, logic [BW-1:0] be,
                              logic [DW-1:0] wdata, logic dreq, logic [AW-1:0] daddr,
                              logic e_gnt, logic e_wait, logic [DW-1:0] e_rdata,
                              logic e_dvalid, logic [DW-1:0] e_ddata);
    vec_t v;
    v.cs = cs; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.dreq = dreq; v.daddr = daddr; v.e_gnt = e_gnt; v.e_wait = e_wait;
    v.e_rdata = e_rdata; v.e_dvalid = e_dvalid; v.e_ddata = e_ddata;
    return v;
  endfunction

  vec_t vt [12];

  initial begin
    int n, st;
    bit cpu_busy, disp_busy;

    vt[0]  = mk(1, 0, 1, 5,   4'b0011, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    vt[1]  = mk(1, 1, 0, 5,   4'h0, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
    vt[2]  = mk(1, 1, 0, 5,   4'h0, 32'h0, 0, 0, 0, 0, 32'hC0DEBEEF, 0, 32'h0);
    vt[3]  = mk(0, 0, 0, 0,   4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    vt[4]  = mk(1, 1, 0, 100, 4'h0, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
    vt[5]  = mk(1, 1, 0, 100, 4'h0, 32'h0, 1, 9, 1, 0, 32'hC0DE0064, 0, 32'h0);
    vt[6]  = mk(0, 0, 0, 0,   4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'hC0DE0009);
    vt[7]  = mk(1, 1, 1, 6,   4'hF, 32'h12345678, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    vt[8]  = mk(1, 1, 0, 6,   4'h0, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
    vt[9]  = mk(1, 1, 0, 6,   4'h0, 32'h0, 0, 0, 0, 0, 32'h12345678, 0, 32'h0);
    vt[10] = mk(0, 1, 0, 6,   4'h0, 32'h0, 1, 6, 1, 0, 32'h0, 0, 32'h0);
    vt[11] = mk(0, 0, 0, 0,   4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h12345678);

    for (int i = 0; i < 8192; i++) gold[i] = 32'hC0DE0000 | 32'(i);
    lost = 0; m_cpu_ret = 0; m_disp_ret = 0; m_cpu_data = '0; m_disp_data = '0;
    idle_inputs();
    preload = 1; RESET = 1;
    @(negedge clk);
    preload = 0;
    @(negedge clk);
    RESET = 0;

    // Reset state with no traffic
    sample();
    chk("rst_disp_gnt", 32'(DISP_GNT), 32'h0);
    chk("rst_rden", 32'(RAM_RDEN), 32'h0);
    chk("rst_wren", 32'(RAM_WREN), 32'h0);
    chk("rst_disp_valid", 32'(DISP_VALID), 32'h0);
    chk("rst_readdata", AVL_READDATA, 32'h0);
    chk("rst_disp_data", DISP_DATA, 32'h0);
    chk("rst_byte_en", 32'(RAM_BYTE_EN), 32'hF);
    advance();

    // Sixteen back-to-back display reads
    for (int i = 0; i < 16; i++) begin
      DISP_REQ = 1; DISP_ADDR = AW'(i);
      sample();
      chk("stream_gnt", 32'(DISP_GNT), 32'h1);
      if (i > 0) begin
        chk("stream_valid", 32'(DISP_VALID), 32'h1);
        chk("stream_data", DISP_DATA, 32'hC0DE0000 | 32'(i - 1));
      end
      advance();
    end
    idle_inputs();
    sample();
    chk("stream_last_data", DISP_DATA, 32'hC0DE000F);
    advance();

    // Table-driven vectors
    foreach (vt[i]) begin
      AVL_CS = vt[i].cs; AVL_READ = vt[i].rd; AVL_WRITE = vt[i].wr; AVL_ADDR = vt[i].addr;
      AVL_BYTE_EN = vt[i].be; AVL_WRITEDATA = vt[i].wdata;
      DISP_REQ = vt[i].dreq; DISP_ADDR = vt[i].daddr;
      sample();
      chk($sformatf("vec%0d_gnt", i), 32'(DISP_GNT), 32'(vt[i].e_gnt));
      chk($sformatf("vec%0d_wait", i), 32'(AVL_WAITREQUEST), 32'(vt[i].e_wait));
      chk($sformatf("vec%0d_rdata", i), AVL_READDATA, vt[i].e_rdata);
      chk($sformatf("vec%0d_dvalid", i), 32'(DISP_VALID), 32'(vt[i].e_dvalid));
      chk($sformatf("vec%0d_ddata", i), DISP_DATA, vt[i].e_ddata);
      advance();
    end
    idle_inputs();

    // Starvation bound under continuous display requests; second run shows the counter cleared
    DISP_REQ = 1; DISP_ADDR = 200;
    starve_read(100, n, st);
    chk("starve1_grant_cycle", 32'(n), 32'd5);
    chk("starve1_disp_stalls", 32'(st), 32'd1);
    starve_read(101, n, st);
    chk("starve2_grant_cycle", 32'(n), 32'd5);
    chk("starve2_disp_stalls", 32'(st), 32'd1);
    idle_inputs();
    sample();
    advance();

    // Reset pulsed while the CPU read is returning
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 20;
    sample();
    chk("rstmid_grant_wait", 32'(AVL_WAITREQUEST), 32'h1);
    advance();
    RESET = 1; DISP_REQ = 1; DISP_ADDR = 3;
    sample();
    chk("rstmid_disp_gnt_in_ret", 32'(DISP_GNT), 32'h1);
    advance();
    RESET = 0; DISP_REQ = 0;
    sample();
    chk("rstmid_disp_valid", 32'(DISP_VALID), 32'h0);
    chk("rstmid_rearb_wait", 32'(AVL_WAITREQUEST), 32'h1);
    chk("rstmid_rearb_rden", 32'(RAM_RDEN), 32'h1);
    advance();
    sample();
    chk("rstmid_done_wait", 32'(AVL_WAITREQUEST), 32'h0);
    chk("rstmid_done_data", AVL_READDATA, 32'hC0DE0014);
    advance();
    idle_inputs();

    // Randomized protocol-legal traffic against the model
    cpu_busy = 0; disp_busy = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!cpu_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 2);
          cpu_busy = 1; AVL_CS = 1;
          AVL_READ = (kind != 1); AVL_WRITE = (kind != 0);
          AVL_ADDR = AW'($urandom_range(0, 31)); AVL_BYTE_EN = BW'($urandom);
          AVL_WRITEDATA = $urandom;
        end else begin
          AVL_CS = 0; AVL_READ = 1'($urandom); AVL_WRITE = 1'($urandom);
          AVL_ADDR = AW'($urandom_range(0, 31));
        end
      end
      if (!disp_busy) begin
        DISP_REQ = 1'($urandom);
        disp_busy = DISP_REQ;
        DISP_ADDR = AW'($urandom_range(0, 31));
      end
      RESET = ($urandom_range(0, 199) == 0);
      sample();
      if (cpu_busy && !e_wait) cpu_busy = 0;
      if (disp_busy && disp_wins) disp_busy = 0;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
